sram_responder: RTL and testbench

//   Synthesizable 16-bit async-SRAM responder that stands in place of the external
//   IS61WV25616 on the pin side of the external memory controller, for board and

---
 rtl/sram_responder_pkg.sv | 19 +
 rtl/sram_responder_mem.sv | 24 ++
 rtl/sram_responder.sv | 160 ++++++++++++++++
 tb/tb_sram_responder.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_responder_pkg.sv
// Shared definitions for the SRAM responder: FSM state encodings and
// the bit positions of the sticky error flags.
package sram_responder_pkg;

    localparam int HALF_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_L1   = 2'd1,
        ST_L2   = 2'd2,
        ST_H    = 2'd3
    } state_t;

    localparam int ERR_CONTENTION = 0;
    localparam int ERR_SEQUENCE   = 1;
    localparam int ERR_DIR_CHANGE = 2;
    localparam int ERR_STRAY_WE   = 3;

endpackage

// File: rtl/sram_responder_mem.sv
// Half-word store: asynchronous read, synchronous write, contents never reset.
module sram_responder_mem
    import sram_responder_pkg::*;
#(
    parameter int AW = 10
) (
    input  logic              clock,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [HALF_W-1:0] wdata,
    output logic [HALF_W-1:0] rdata
);

    logic [HALF_W-1:0] store [2**AW];

    always_ff @(posedge clock) begin
        if (we) begin
            store[addr] <= wdata;
        end
    end

    assign rdata = store[addr];

endmodule

// File: rtl/sram_responder.sv
// Stand-in for the external async SRAM: serves reads, commits writes, follows
// the controller's L,L,H half-word sequence and reports completed words/errors.
//
//   state   | meaning
//   IDLE    | no word in progress (deselected, or after an error)
//   L1      | first low-half access seen, key latched
//   L2      | second low-half access seen, low half latched
//   H       | high half accepted, word reported; next low half may follow
module sram_responder
    import sram_responder_pkg::*;
#(
    parameter int AW = 10,
    parameter int CW = 16
) (
    input  logic              clock,
    input  logic              reset_b,
    input  logic              ram_cs_b,
    input  logic              ram_oe_b,
    input  logic              ram_we_b,
    input  logic [17:0]       ram_addr,
    input  logic [HALF_W-1:0] ram_wdata,
    input  logic              ram_wdata_oe,
    output logic [HALF_W-1:0] ram_rdata,
    input  logic              err_clear,
    output logic              word_valid,
    output logic              word_is_write,
    output logic [31:0]       last_word,
    output logic [16:0]       last_addr,
    output logic [CW-1:0]     rd_count,
    output logic [CW-1:0]     wr_count,
    output logic [3:0]        err_flags
);

    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

    state_t            state, state_next;
    logic [16:0]       key_addr;
    logic              key_oe_b;
    logic [HALF_W-1:0] low_half;
    logic [HALF_W-1:0] mem_rdata;
    logic [HALF_W-1:0] half_in;
    logic              load_key, load_low, word_done;
    logic [3:0]        errs;
    logic              a0, same_addr, same_dir, mem_we;

    assign mem_we = !ram_cs_b && ram_oe_b && ram_wdata_oe;

    sram_responder_mem #(.AW(AW)) u_mem (
        .clock (clock),
        .we    (mem_we),
        .addr  (ram_addr[AW-1:0]),
        .wdata (ram_wdata),
        .rdata (mem_rdata)
    );

    assign ram_rdata = (!ram_cs_b && !ram_oe_b) ? mem_rdata : '0;
    assign half_in   = ram_oe_b ? ram_wdata : mem_rdata;
    assign a0        = ram_addr[0];
    assign same_addr = (ram_addr[17:1] == key_addr);
    assign same_dir  = (ram_oe_b == key_oe_b);

    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load_key   = 1'b0;
        load_low   = 1'b0;
        word_done  = 1'b0;
        errs       = '0;
        errs[ERR_CONTENTION] = !ram_cs_b && !ram_oe_b && ram_wdata_oe;
        errs[ERR_STRAY_WE]   = !ram_we_b && (!ram_oe_b || ram_cs_b);
        unique case (state)
            ST_IDLE, ST_H: begin
                // H behaves like IDLE for the next sample: a new word may start at once
                if (ram_cs_b) begin
                    state_next = ST_IDLE;
                end else if (!a0) begin
                    state_next = ST_L1;
                    load_key   = 1'b1;
                end else begin
                    state_next = ST_IDLE;
                    errs[ERR_SEQUENCE] = 1'b1;
                end
            end
            ST_L1, ST_L2: begin
                if (!ram_cs_b && same_addr && same_dir && (a0 == (state == ST_L2))) begin
                    if (state == ST_L1) begin
                        state_next = ST_L2;
                        load_low   = 1'b1;
                    end else begin
                        state_next = ST_H;
                        word_done  = 1'b1;
                    end
                end else begin
                    if (!ram_cs_b && !same_dir) begin
                        errs[ERR_DIR_CHANGE] = 1'b1;
                    end else begin
                        errs[ERR_SEQUENCE] = 1'b1;
                    end
                    if (!ram_cs_b && !a0) begin
                        state_next = ST_L1;
                        load_key   = 1'b1;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            key_addr      <= '0;
            key_oe_b      <= 1'b1;
            low_half      <= '0;
            word_valid    <= 1'b0;
            word_is_write <= 1'b0;
            last_word     <= '0;
            last_addr     <= '0;
            rd_count      <= '0;
            wr_count      <= '0;
            err_flags     <= '0;
        end else begin
            word_valid <= word_done;
            if (load_key) begin
                key_addr <= ram_addr[17:1];
                key_oe_b <= ram_oe_b;
            end
            if (load_low) begin
                low_half <= half_in;
            end
            if (word_done) begin
                last_word     <= {half_in, low_half};
                last_addr     <= key_addr;
                word_is_write <= key_oe_b;
            end
            if (err_clear) begin
                rd_count <= '0;
                wr_count <= '0;
            end else if (word_done) begin
                if (key_oe_b && wr_count != {CW{1'b1}}) begin
                    wr_count <= wr_count + CNT_ONE;
                end
                if (!key_oe_b && rd_count != {CW{1'b1}}) begin
                    rd_count <= rd_count + CNT_ONE;
                end
            end
            // a flag raised in the clearing cycle survives the clear
            err_flags <= (err_clear ? 4'b0000 : err_flags) | errs;
        end
    end

endmodule

// File: tb/tb_sram_responder.sv
// Randomized bench for sram_responder against a word-level reference model,
// plus directed scenarios with literal expectations.
module tb_sram_responder;

    localparam int AW   = 10;
    localparam int CW   = 4;   // narrow counters so saturation is reachable quickly
    localparam int CMAX = (1 << CW) - 1;

    logic          clock = 1'b0;
    logic          reset_b = 1'b0;
    logic          ram_cs_b = 1'b1;
    logic          ram_oe_b = 1'b1;
    logic          ram_we_b = 1'b1;
    logic [17:0]   ram_addr = '0;
    logic [15:0]   ram_wdata = '0;
    logic          ram_wdata_oe = 1'b0;
    logic [15:0]   ram_rdata;
    logic          err_clear = 1'b0;
    logic          word_valid;
    logic          word_is_write;
    logic [31:0]   last_word;
    logic [16:0]   last_addr;
    logic [CW-1:0] rd_count;
    logic [CW-1:0] wr_count;
    logic [3:0]    err_flags;

    sram_responder #(.AW(AW), .CW(CW)) dut (
        .clock(clock), .reset_b(reset_b), .ram_cs_b(ram_cs_b), .ram_oe_b(ram_oe_b),
        .ram_we_b(ram_we_b), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_wdata_oe(ram_wdata_oe), .ram_rdata(ram_rdata), .err_clear(err_clear),
        .word_valid(word_valid), .word_is_write(word_is_write), .last_word(last_word),
        .last_addr(last_addr), .rd_count(rd_count), .wr_count(wr_count), .err_flags(err_flags)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;
    int n_wv  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [16:0] wa;
        logic        oe_b;
        logic [15:0] d;
    } samp_t;

    logic [15:0]   mdl_mem [2**AW];
    samp_t         cur[$];
    logic          m_valid = 1'b0;
    logic          m_isw = 1'b0;
    logic [31:0]   m_word = '0;
    logic [16:0]   m_addr = '0;
    int            m_rd = 0;
    int            m_wr = 0;
    logic [3:0]    m_err = '0;

    always @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            cur.delete();
            m_valid = 1'b0; m_isw = 1'b0; m_word = '0; m_addr = '0;
            m_rd = 0; m_wr = 0; m_err = '0;
        end else begin
            samp_t      s;
            logic [3:0] e;
            bit         done;
            e = '0;
            done = 0;
            s.wa   = ram_addr[17:1];
            s.oe_b = ram_oe_b;
            s.d    = ram_oe_b ? ram_wdata : mdl_mem[ram_addr[AW-1:0]];
            if (!ram_cs_b && !ram_oe_b && ram_wdata_oe) e[0] = 1'b1;
            if (!ram_we_b && (!ram_oe_b || ram_cs_b)) e[3] = 1'b1;
            if (ram_cs_b) begin
                if (cur.size() != 0) e[1] = 1'b1;
                cur.delete();
            end else if (cur.size() == 0) begin
                if (!ram_addr[0]) cur.push_back(s);
                else e[1] = 1'b1;
            end else if (s.wa == cur[0].wa && s.oe_b == cur[0].oe_b &&
                         ram_addr[0] == (cur.size() == 2)) begin
                cur.push_back(s);
                if (cur.size() == 3) begin
                    done   = 1;
                    m_word = {cur[2].d, cur[1].d};
                    m_addr = cur[0].wa;
                    m_isw  = cur[0].oe_b;
                    cur.delete();
                end
            end else begin
                if (s.oe_b != cur[0].oe_b) e[2] = 1'b1;
                else e[1] = 1'b1;
                cur.delete();
                if (!ram_addr[0]) cur.push_back(s);
            end
            if (!ram_cs_b && ram_oe_b && ram_wdata_oe) mdl_mem[ram_addr[AW-1:0]] = ram_wdata;
            m_valid = done;
            if (err_clear) begin
                m_rd = 0;
                m_wr = 0;
            end else if (done) begin
                if (m_isw) m_wr = (m_wr < CMAX) ? m_wr + 1 : CMAX;
                else       m_rd = (m_rd < CMAX) ? m_rd + 1 : CMAX;
            end
            m_err = (err_clear ? 4'b0000 : m_err) | e;
        end
    end

    always @(negedge clock) begin
        logic [15:0] exp_rd;
        exp_rd = (!ram_cs_b && !ram_oe_b) ? mdl_mem[ram_addr[AW-1:0]] : 16'h0000;
        if (word_valid) n_wv++;
        chk("ram_rdata", 32'(ram_rdata), 32'(exp_rd));
        chk("word_valid", 32'(word_valid), 32'(m_valid));
        chk("word_is_write", 32'(word_is_write), 32'(m_isw));
        chk("last_word", last_word, m_word);
        chk("last_addr", 32'(last_addr), 32'(m_addr));
        chk("rd_count", 32'(rd_count), 32'(m_rd));
        chk("wr_count", 32'(wr_count), 32'(m_wr));
        chk("err_flags", 32'(err_flags), 32'(m_err));
    end

    // ---------------- stimulus ----------------
    task automatic set(input logic cs, input logic oe, input logic we, input logic [17:0] a,
                       input logic [15:0] wd, input logic wdoe, input logic clr);
        ram_cs_b = cs; ram_oe_b = oe; ram_we_b = we; ram_addr = a;
        ram_wdata = wd; ram_wdata_oe = wdoe; err_clear = clr;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic half(input logic cs, input logic oe, input logic we, input logic [17:0] a,
                        input logic [15:0] wd, input logic wdoe, input logic clr);
        set(cs, oe, we, a, wd, wdoe, clr);
        tick();
    endtask

    task automatic idle(input logic clr);
        half(1'b1, 1'b1, 1'b1, '0, '0, 1'b0, clr);
    endtask

    task automatic write_word(input logic [16:0] w, input logic [31:0] d);
        half(1'b0, 1'b1, 1'b0, {w, 1'b0}, d[15:0], 1'b1, 1'b0);
        half(1'b0, 1'b1, 1'b0, {w, 1'b0}, d[15:0], 1'b1, 1'b0);
        half(1'b0, 1'b1, 1'b0, {w, 1'b1}, d[31:16], 1'b1, 1'b0);
    endtask

    task automatic read_word(input logic [16:0] w);
        half(1'b0, 1'b0, 1'b1, {w, 1'b0}, '0, 1'b0, 1'b0);
        half(1'b0, 1'b0, 1'b1, {w, 1'b0}, '0, 1'b0, 1'b0);
        half(1'b0, 1'b0, 1'b1, {w, 1'b1}, '0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wv0;
        tick(); tick();
        chk("reset err_flags", 32'(err_flags), 32'h0);
        chk("reset last_word", last_word, 32'h0);
        reset_b = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) write_word(17'(i), $urandom);
        idle(1'b1);
        idle(1'b0);

        // 1: write DEADBEEF at word 5
        wv0 = n_wv;
        write_word(17'h00005, 32'hDEADBEEF);
        idle(1'b0);
        chk("t1 word_valid pulses", 32'(n_wv - wv0), 32'd1);
        chk("t1 wr_count", 32'(wr_count), 32'd1);
        chk("t1 err_flags", 32'(err_flags), 32'h0);
        chk("t1 word_is_write", 32'(word_is_write), 32'd1);

        // 2: read it back, checking the bus halves
        set(1'b0, 1'b0, 1'b1, {17'h00005, 1'b0}, '0, 1'b0, 1'b0);
        #1 chk("t2 rdata L1", 32'(ram_rdata), 32'h0000BEEF);
        tick();
        #1 chk("t2 rdata L2", 32'(ram_rdata), 32'h0000BEEF);
        tick();
        set(1'b0, 1'b0, 1'b1, {17'h00005, 1'b1}, '0, 1'b0, 1'b0);
        #1 chk("t2 rdata H", 32'(ram_rdata), 32'h0000DEAD);
        tick();
        idle(1'b0);
        chk("t2 last_word", last_word, 32'hDEADBEEF);
        chk("t2 last_addr", 32'(last_addr), 32'h00005);
        chk("t2 rd_count", 32'(rd_count), 32'd1);

        // 3: back-to-back reads
        wv0 = n_wv;
        read_word(17'h00001);
        read_word(17'h00002);
        idle(1'b0);
        chk("t3 word_valid pulses", 32'(n_wv - wv0), 32'd2);
        chk("t3 err_flags", 32'(err_flags), 32'h0);
        chk("t3 rd_count", 32'(rd_count), 32'd3);

        // 4: lone high half, then truncated word
        half(1'b0, 1'b0, 1'b1, {17'h00003, 1'b1}, '0, 1'b0, 1'b0);
        half(1'b0, 1'b0, 1'b1, {17'h00003, 1'b0}, '0, 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b0);
        chk("t4 err_flags", 32'(err_flags), 32'b0010);
        chk("t4 rd_count", 32'(rd_count), 32'd3);
        chk("t4 wr_count", 32'(wr_count), 32'd1);

        // 5: contention, then direction flip, then clear
        idle(1'b1);
        half(1'b0, 1'b0, 1'b1, {17'h00004, 1'b0}, '0, 1'b1, 1'b0);
        half(1'b0, 1'b0, 1'b1, {17'h00004, 1'b0}, '0, 1'b1, 1'b0);
        half(1'b0, 1'b0, 1'b1, {17'h00004, 1'b1}, '0, 1'b1, 1'b0);
        idle(1'b0);
        chk("t5 contention", 32'(err_flags), 32'b0001);
        idle(1'b1);
        half(1'b0, 1'b1, 1'b0, {17'h00005, 1'b0}, 16'hBEEF, 1'b1, 1'b0);
        read_word(17'h00005);
        idle(1'b0);
        chk("t5 dir change", 32'(err_flags), 32'b0100);
        idle(1'b1);
        idle(1'b0);
        chk("t5 clear err", 32'(err_flags), 32'h0);
        chk("t5 clear rd", 32'(rd_count), 32'h0);

        // 6: reset while in L2
        wv0 = n_wv;
        half(1'b0, 1'b0, 1'b1, {17'h00005, 1'b0}, '0, 1'b0, 1'b0);
        half(1'b0, 1'b0, 1'b1, {17'h00005, 1'b0}, '0, 1'b0, 1'b0);
        set(1'b0, 1'b0, 1'b1, {17'h00005, 1'b1}, '0, 1'b0, 1'b0);
        reset_b = 1'b0;
        tick();
        set(1'b1, 1'b1, 1'b1, '0, '0, 1'b0, 1'b0);
        tick();
        reset_b = 1'b1;
        idle(1'b0);
        idle(1'b0);
        chk("t6 no word_valid", 32'(n_wv - wv0), 32'd0);
        chk("t6 err_flags", 32'(err_flags), 32'h0);
        read_word(17'h00005);
        idle(1'b0);
        chk("t6 readback", last_word, 32'hDEADBEEF);

        // 7: write counter saturation
        idle(1'b1);
        for (int i = 0; i < CMAX - 1; i++) write_word(17'(i % 8), $urandom);
        idle(1'b0);
        chk("t7 wr_count max-1", 32'(wr_count), 32'(CMAX - 1));
        for (int i = 0; i < 3; i++) write_word(17'(i), $urandom);
        idle(1'b0);
        chk("t7 wr_count saturated", 32'(wr_count), 32'(CMAX));

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            int          k;
            logic [16:0] w;
            k = $urandom_range(0, 11);
            w = {14'($urandom), 3'($urandom_range(0, 7))};
            if (k < 3) read_word(w);
            else if (k < 6) write_word(w, $urandom);
            else if (k < 9)
                half(1'($urandom), 1'($urandom), 1'($urandom), {w, 1'($urandom)},
                     16'($urandom), 1'($urandom), ($urandom_range(0, 15) == 0));
            else if (k < 11) idle(1'b0);
            else idle(1'b1);
        end
        idle(1'b0);
        idle(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
